// File: rtl/ex_mdu_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : ex_mdu_alu
//  Purpose  : EX-stage execute unit. Single-cycle RV32I-style ALU ops plus an
//             iterative RV-M multiply/divide engine. The engine retires
//             MD_STEP bits per cycle. Results are registered and held until
//             the consumer takes them.
//  Ports    : clk, rst (sync, active-high), flush
//             in_valid/in_ready   - operation handshake
//             alu_ctrl[4:0]       - op code
//             alu_dataA/B         - operands, XLEN bits wide
//             out_valid/out_ready - result handshake
//             alu_dataC           - result
//             alu_zero, alu_overflow, compare_res - flags derived from result
//  Revision : 1.0 - initial release
// ============================================================================
module ex_mdu_alu #(
  parameter int XLEN    = 32,
  parameter int MD_STEP = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      alu_ctrl,
  input  logic [XLEN-1:0] alu_dataA,
  input  logic [XLEN-1:0] alu_dataB,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_dataC,
  output logic            alu_zero,
  output logic            alu_overflow,
  output logic            compare_res
);

  localparam int SHW   = $clog2(XLEN);
  localparam int NSTEP = XLEN / MD_STEP;
  localparam int CNTW  = $clog2(NSTEP + 1);

  localparam logic [4:0] OP_ADD = 5'b00000, OP_SUB  = 5'b00001, OP_OR  = 5'b00010,
                         OP_AND = 5'b00011, OP_XOR  = 5'b00100, OP_SRL = 5'b00101,
                         OP_SLL = 5'b00110, OP_SRA  = 5'b00111, OP_SLT = 5'b01000,
                         OP_SLTU = 5'b01001;
  localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t             state_q, state_d;
  logic [CNTW-1:0]    cnt_q;
  logic [XLEN-1:0]    res_q, res_d;
  logic               zero_q, ovf_q, ovf_d;
  logic               load_res, start_md, accept;
  // Multi-cycle engine: hi = partial product high / remainder,
  // lo = multiplier / dividend-then-quotient, b = multiplicand / divisor.
  logic [XLEN-1:0]    md_hi_q, md_lo_q, md_b_q;
  logic [2:0]         md_op_q;
  logic               md_negp_q, md_negr_q;

  logic [SHW-1:0]     shamt;
  logic [XLEN-1:0]    sum, diff, base_res;
  logic               base_ovf;
  logic               is_md, is_div, a_sgn, b_sgn, a_neg, b_neg;
  logic [XLEN-1:0]    a_mag, b_mag;
  logic               div_zero, div_ovf, special;
  logic [XLEN-1:0]    special_res;

  logic [XLEN-1:0]    st_hi, st_lo, fin_res;
  logic [XLEN:0]      rem_t, add_t;
  logic               qbit;
  logic [2*XLEN-1:0]  prod, prod_s;

  // ---------------- single-cycle ALU ----------------
  assign shamt = alu_dataB[SHW-1:0];
  assign sum   = alu_dataA + alu_dataB;
  assign diff  = alu_dataA - alu_dataB;

  always_comb begin
    base_res = '0;
    base_ovf = 1'b0;
    case (alu_ctrl)
      OP_ADD: begin
        base_res = sum;
        base_ovf = (alu_dataA[XLEN-1] == alu_dataB[XLEN-1]) && (sum[XLEN-1] != alu_dataA[XLEN-1]);
      end
      OP_SUB: begin
        base_res = diff;
        base_ovf = (alu_dataA[XLEN-1] != alu_dataB[XLEN-1]) && (diff[XLEN-1] != alu_dataA[XLEN-1]);
      end
      OP_OR:   base_res = alu_dataA | alu_dataB;
      OP_AND:  base_res = alu_dataA & alu_dataB;
      OP_XOR:  base_res = alu_dataA ^ alu_dataB;
      OP_SRL:  base_res = alu_dataA >> shamt;
      OP_SLL:  base_res = alu_dataA << shamt;
      OP_SRA:  base_res = $signed(alu_dataA) >>> shamt;
      OP_SLT:  base_res = {{(XLEN-1){1'b0}}, $signed(alu_dataA) < $signed(alu_dataB)};
      OP_SLTU: base_res = {{(XLEN-1){1'b0}}, alu_dataA < alu_dataB};
      default: base_res = '0;
    endcase
  end

  // ---------------- M-op decode and operand conditioning ----------------
  // The engine works on magnitudes; signs are reapplied to the final result.
  assign is_md  = (alu_ctrl[4:3] == 2'b10);
  assign is_div = is_md & alu_ctrl[2];
  assign a_sgn  = is_md & (alu_ctrl[2] ? ~alu_ctrl[0] : (alu_ctrl[1] ^ alu_ctrl[0]));
  assign b_sgn  = is_md & (alu_ctrl[2] ? ~alu_ctrl[0] : (alu_ctrl[1:0] == 2'b01));
  assign a_neg  = a_sgn & alu_dataA[XLEN-1];
  assign b_neg  = b_sgn & alu_dataB[XLEN-1];
  assign a_mag  = a_neg ? -alu_dataA : alu_dataA;
  assign b_mag  = b_neg ? -alu_dataB : alu_dataB;

  // Divide corner cases resolve immediately instead of iterating.
  assign div_zero = is_div & (alu_dataB == '0);
  assign div_ovf  = is_div & ~alu_ctrl[0] & (alu_dataA == SMIN) & (alu_dataB == '1);
  assign special  = div_zero | div_ovf;
  assign special_res = div_zero ? (alu_ctrl[1] ? alu_dataA : '1)
                                : (alu_ctrl[1] ? '0 : SMIN);

  // ---------------- iteration step (MD_STEP bits) ----------------
  always_comb begin
    st_hi = md_hi_q;
    st_lo = md_lo_q;
    rem_t = '0;
    add_t = '0;
    qbit  = 1'b0;
    for (int i = 0; i < MD_STEP; i++) begin
      if (md_op_q[2]) begin
        // restoring division: shift one dividend bit into the remainder
        rem_t = {st_hi, st_lo[XLEN-1]};
        qbit  = (rem_t >= {1'b0, md_b_q});
        if (qbit) rem_t = rem_t - {1'b0, md_b_q};
        st_hi = rem_t[XLEN-1:0];
        st_lo = {st_lo[XLEN-2:0], qbit};
      end else begin
        // shift-add multiply: conditional add, then shift {carry,hi,lo} right
        add_t = {1'b0, st_hi} + (st_lo[0] ? {1'b0, md_b_q} : '0);
        st_lo = {add_t[0], st_lo[XLEN-1:1]};
        st_hi = add_t[XLEN:1];
      end
    end
  end

  assign prod   = {st_hi, st_lo};
  assign prod_s = md_negp_q ? -prod : prod;

  always_comb begin
    fin_res = '0;
    if (md_op_q[2]) begin
      if (md_op_q[1]) fin_res = md_negr_q ? -st_hi : st_hi;
      else            fin_res = md_negp_q ? -st_lo : st_lo;
    end else begin
      fin_res = (md_op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
    end
  end

  // ---------------- control FSM ----------------
  assign in_ready = (state_q == S_IDLE) | ((state_q == S_DONE) & out_ready);
  assign accept   = in_valid & in_ready & ~flush;

  always_comb begin
    state_d  = state_q;
    load_res = 1'b0;
    start_md = 1'b0;
    res_d    = '0;
    ovf_d    = 1'b0;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if ((state_q == S_DONE) && out_ready) state_d = S_IDLE;
          if (accept) begin
            if (is_md && !special) begin
              state_d  = S_BUSY;
              start_md = 1'b1;
            end else begin
              state_d  = S_DONE;
              load_res = 1'b1;
              res_d    = is_md ? special_res : base_res;
              ovf_d    = is_md ? 1'b0 : base_ovf;
            end
          end
        end
        S_BUSY: begin
          if (cnt_q == CNTW'(1)) begin
            state_d  = S_DONE;
            load_res = 1'b1;
            res_d    = fin_res;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      res_q     <= '0;
      zero_q    <= 1'b0;
      ovf_q     <= 1'b0;
      md_hi_q   <= '0;
      md_lo_q   <= '0;
      md_b_q    <= '0;
      md_op_q   <= '0;
      md_negp_q <= 1'b0;
      md_negr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (load_res) begin
        res_q  <= res_d;
        zero_q <= (res_d == '0);
        ovf_q  <= ovf_d;
      end
      if (start_md) begin
        md_hi_q   <= '0;
        md_lo_q   <= is_div ? a_mag : b_mag;
        md_b_q    <= is_div ? b_mag : a_mag;
        md_op_q   <= alu_ctrl[2:0];
        md_negp_q <= a_neg ^ b_neg;
        md_negr_q <= a_neg;
        cnt_q     <= CNTW'(NSTEP);
      end else if (state_q == S_BUSY) begin
        md_hi_q <= st_hi;
        md_lo_q <= st_lo;
        cnt_q   <= cnt_q - CNTW'(1);
      end
    end
  end

  assign out_valid    = (state_q == S_DONE);
  assign alu_dataC    = res_q;
  assign alu_zero     = zero_q;
  assign alu_overflow = ovf_q;
  assign compare_res  = res_q[0];

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu_alu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_ex_mdu_alu
//  Purpose  : Directed self-checking bench for ex_mdu_alu. One instance at
//             XLEN=32/MD_STEP=1, a second at XLEN=64/MD_STEP=4.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ex_mdu_alu;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, out_ready;
  logic        in_ready, out_valid, alu_zero, alu_overflow, compare_res;
  logic [4:0]  alu_ctrl;
  logic [31:0] alu_dataA, alu_dataB, alu_dataC;

  logic        flush_w, in_valid_w, out_ready_w;
  logic        in_ready_w, out_valid_w, zero_w, ovf_w, cmp_w;
  logic [4:0]  ctrl_w;
  logic [63:0] a_w, b_w, c_w;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ex_mdu_alu #(.XLEN(32), .MD_STEP(1)) u_dut32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_ctrl(alu_ctrl), .alu_dataA(alu_dataA), .alu_dataB(alu_dataB),
    .out_valid(out_valid), .out_ready(out_ready), .alu_dataC(alu_dataC),
    .alu_zero(alu_zero), .alu_overflow(alu_overflow), .compare_res(compare_res)
  );

  ex_mdu_alu #(.XLEN(64), .MD_STEP(4)) u_dut64 (
    .clk(clk), .rst(rst), .flush(flush_w), .in_valid(in_valid_w), .in_ready(in_ready_w),
    .alu_ctrl(ctrl_w), .alu_dataA(a_w), .alu_dataB(b_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w), .alu_dataC(c_w),
    .alu_zero(zero_w), .alu_overflow(ovf_w), .compare_res(cmp_w)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one op on the 32-bit unit with out_ready=1, wait for the result,
  // check latency and value. Leaves the unit in DONE with in_valid low.
  task automatic run32(input string tag, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int lat);
    int n;
    in_valid = 1'b1; alu_ctrl = op; alu_dataA = a; alu_dataB = b;
    tick();
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 200) begin tick(); n++; end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk(tag, 64'(alu_dataC), 64'(exp));
  endtask

  task automatic run64(input string tag, input logic [4:0] op, input logic [63:0] a,
                       input logic [63:0] b, input logic [63:0] exp, input int lat);
    int n;
    in_valid_w = 1'b1; ctrl_w = op; a_w = a; b_w = b;
    tick();
    in_valid_w = 1'b0;
    n = 1;
    while (!out_valid_w && n < 200) begin tick(); n++; end
    chk({tag, " latency"}, 64'(n), 64'(lat));
    chk(tag, c_w, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "simulation did not finish");
  end

  initial begin
    int seen;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_ctrl = '0; alu_dataA = '0; alu_dataB = '0;
    flush_w = 1'b0; in_valid_w = 1'b0; out_ready_w = 1'b1;
    ctrl_w = '0; a_w = '0; b_w = '0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst in_ready",  64'(in_ready), 64'd1);
    chk("rst out_valid", 64'(out_valid), 64'd0);
    chk("rst dataC",     64'(alu_dataC), 64'd0);
    chk("rst zero",      64'(alu_zero), 64'd0);
    chk("rst overflow",  64'(alu_overflow), 64'd0);
    chk("rst compare",   64'(compare_res), 64'd0);

    // add with signed overflow
    run32("add ovf", 5'b00000, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
    chk("add ovf flag",  64'(alu_overflow), 64'd1);
    chk("add zero flag", 64'(alu_zero), 64'd0);

    // back-to-back base ops, one result per cycle
    in_valid = 1'b1; alu_ctrl = 5'b00001; alu_dataA = 32'd5; alu_dataB = 32'd5;
    tick();
    chk("b2b sub C",    64'(alu_dataC), 64'd0);
    chk("b2b sub zero", 64'(alu_zero), 64'd1);
    chk("b2b sub ovf",  64'(alu_overflow), 64'd0);
    alu_ctrl = 5'b01001; alu_dataA = 32'd1; alu_dataB = 32'hFFFF_FFFF;
    tick();
    chk("b2b sltu C",   64'(alu_dataC), 64'd1);
    chk("b2b sltu cmp", 64'(compare_res), 64'd1);
    chk("b2b sltu valid", 64'(out_valid), 64'd1);
    alu_ctrl = 5'b00111; alu_dataA = 32'h8000_0000; alu_dataB = 32'd4;
    tick();
    chk("b2b sra C", 64'(alu_dataC), 64'hF800_0000);
    in_valid = 1'b0;
    tick();
    chk("consume out_valid", 64'(out_valid), 64'd0);

    // further base ops and boundaries
    run32("slt -1<1",     5'b01000, 32'hFFFF_FFFF, 32'd1, 32'd1, 1);
    run32("slt 1<-1",     5'b01000, 32'd1, 32'hFFFF_FFFF, 32'd0, 1);
    run32("sub ovf",      5'b00001, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1);
    chk("sub ovf flag", 64'(alu_overflow), 64'd1);
    run32("srl by 0",     5'b00101, 32'h1234_5678, 32'd0, 32'h1234_5678, 1);
    run32("sll by 32",    5'b00110, 32'h0000_ABCD, 32'd32, 32'h0000_ABCD, 1);
    run32("sll by 31",    5'b00110, 32'd1, 32'd31, 32'h8000_0000, 1);
    run32("srl by 4",     5'b00101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1);
    run32("xor",          5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    run32("and",          5'b00011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1);
    run32("or",           5'b00010, 32'hF0F0_F0F0, 32'h0F00_0F00, 32'hFFF0_FFF0, 1);
    run32("bad op",       5'b01101, 32'h7FFF_FFFF, 32'h1, 32'd0, 1);
    chk("bad op ovf", 64'(alu_overflow), 64'd0);

    // iterative multiply, busy handshake
    in_valid = 1'b1; alu_ctrl = 5'b10001; alu_dataA = 32'hFFFF_FFFF; alu_dataB = 32'hFFFF_FFFF;
    tick();
    in_valid = 1'b0;
    chk("busy in_ready",  64'(in_ready), 64'd0);
    chk("busy out_valid", 64'(out_valid), 64'd0);
    seen = 1;
    while (!out_valid && seen < 200) begin tick(); seen++; end
    chk("mulh latency", 64'(seen), 64'd33);
    chk("mulh -1*-1",   64'(alu_dataC), 64'd0);
    run32("mulhu max",   5'b10011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
    run32("mulhsu -1*max", 5'b10010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
    run32("mul low",     5'b10000, 32'h0001_0003, 32'h0000_0007, 32'h0007_0015, 33);
    run32("mul neg",     5'b10000, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFA, 33);

    // divide: special cases and iterative
    run32("div by 0",    5'b10100, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run32("rem by 0",    5'b10110, 32'd7, 32'd0, 32'd7, 1);
    run32("divu by 0",   5'b10101, 32'd7, 32'd0, 32'hFFFF_FFFF, 1);
    run32("remu by 0",   5'b10111, 32'd7, 32'd0, 32'd7, 1);
    run32("div ovf",     5'b10100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run32("rem ovf",     5'b10110, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run32("rem -7/2",    5'b10110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run32("div -7/2",    5'b10100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run32("divu 100/7",  5'b10101, 32'd100, 32'd7, 32'd14, 33);
    run32("remu 100/7",  5'b10111, 32'd100, 32'd7, 32'd2, 33);

    // backpressure: result held, new op ignored, then accepted on release
    run32("hold add", 5'b00000, 32'd3, 32'd4, 32'd7, 1);
    out_ready = 1'b0;
    in_valid = 1'b1; alu_ctrl = 5'b00000; alu_dataA = 32'd10; alu_dataB = 32'd20;
    #1;
    chk("hold in_ready comb", 64'(in_ready), 64'd0);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold C stable",  64'(alu_dataC), 64'd7);
      chk("hold in_ready",  64'(in_ready), 64'd0);
      chk("hold out_valid", 64'(out_valid), 64'd1);
    end
    out_ready = 1'b1;
    #1;
    chk("release in_ready", 64'(in_ready), 64'd1);
    tick();
    in_valid = 1'b0;
    chk("release accept C", 64'(alu_dataC), 64'd30);
    chk("release valid",    64'(out_valid), 64'd1);

    // flush during divu iteration
    in_valid = 1'b1; alu_ctrl = 5'b10101; alu_dataA = 32'd100; alu_dataB = 32'd7;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush busy out_valid", 64'(out_valid), 64'd0);
    chk("flush busy in_ready",  64'(in_ready), 64'd1);
    chk("flush busy C held",    64'(alu_dataC), 64'd30);
    seen = 0;
    for (int i = 0; i < 40; i++) begin tick(); if (out_valid) seen++; end
    chk("flush no result", 64'(seen), 64'd0);

    // flush in DONE beats a simultaneous accept
    run32("pre flush add", 5'b00000, 32'd1, 32'd1, 32'd2, 1);
    flush = 1'b1; in_valid = 1'b1; alu_ctrl = 5'b00000; alu_dataA = 32'd5; alu_dataB = 32'd5;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush done out_valid", 64'(out_valid), 64'd0);
    chk("flush done C held",    64'(alu_dataC), 64'd2);
    tick();
    chk("flush accept dropped", 64'(out_valid), 64'd0);

    // 64-bit, 4 bits per cycle
    run64("mul64", 5'b10000, 64'h0000_0001_0000_0003, 64'd5, 64'h0000_0005_0000_000F, 17);
    run64("mulhu64", 5'b10011, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
          64'hFFFF_FFFF_FFFF_FFFE, 17);
    run64("add64", 5'b00000, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000, 1);
    chk("add64 ovf", 64'(ovf_w), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
